jtag_scan_sequencer: RTL and testbench

Host-side master that sequences the `tap` controller. It accepts one scan command at a time and generates the cycle-exact TMS/TDI stream that walks the TAP through Run-Test/Idle → IR or DR scan → Run-Test/Idle, capturing TDO into a response word. It shares `tclk`/`trst` with `tap`. It keeps a mirrored copy of the TAP state so the bench can cross-check it against the TAP's one-hot outputs.

---
 rtl/jtag_pkg.sv | 83 ++++++++
 rtl/jtag_tap_mirror.sv | 35 +++
 rtl/jtag_scan_sequencer.sv | 232 +++++++++++++++++++++++
 tb/tb_jtag_scan_sequencer.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/jtag_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : jtag_pkg
//  Description : Shared definitions for the JTAG scan sequencer. Holds the
//                IEEE 1149.1 TAP state encoding, the command op-codes, the
//                sequencer FSM states and the TAP next-state function.
//  Revision    : 1.0  - initial release
// ============================================================================
package jtag_pkg;

  // TAP controller states, using the IEEE 1149.1 reference encoding.
  typedef enum logic [3:0] {
    EXIT2_DR         = 4'h0,
    EXIT1_DR         = 4'h1,
    SHIFT_DR         = 4'h2,
    PAUSE_DR         = 4'h3,
    SELECT_IR_SCAN   = 4'h4,
    UPDATE_DR        = 4'h5,
    CAPTURE_DR       = 4'h6,
    SELECT_DR_SCAN   = 4'h7,
    EXIT2_IR         = 4'h8,
    EXIT1_IR         = 4'h9,
    SHIFT_IR         = 4'hA,
    PAUSE_IR         = 4'hB,
    RUN_TEST_IDLE    = 4'hC,
    UPDATE_IR        = 4'hD,
    CAPTURE_IR       = 4'hE,
    TEST_LOGIC_RESET = 4'hF
  } tap_state_e;

  // Command op-codes.
  localparam logic [1:0] OP_RESET   = 2'd0;
  localparam logic [1:0] OP_IR_SCAN = 2'd1;
  localparam logic [1:0] OP_DR_SCAN = 2'd2;
  localparam logic [1:0] OP_IDLE    = 2'd3;

  // RESET command: this many TMS=1 cycles followed by a single TMS=0.
  localparam int RST_ONES = 5;

  // Sequencer phases. Each state names the phase whose TMS value is on the
  // tms output during that cycle.
  typedef enum logic [3:0] {
    INIT     = 4'd0,
    READY    = 4'd1,
    SEL_DR   = 4'd2,
    SEL_IR   = 4'd3,
    CAPTURE  = 4'd4,
    SHIFT    = 4'd5,
    EXIT1    = 4'd6,
    UPDATE   = 4'd7,
    RST_SEQ  = 4'd8,
    IDLE_CNT = 4'd9,
    DONE     = 4'd10
  } seq_state_e;

  // IEEE 1149.1 TAP next-state function.
  function automatic tap_state_e tap_next_state(input tap_state_e state,
                                                input logic       tms);
    tap_state_e nxt;
    case (state)
      TEST_LOGIC_RESET: nxt = tms ? TEST_LOGIC_RESET : RUN_TEST_IDLE;
      RUN_TEST_IDLE:    nxt = tms ? SELECT_DR_SCAN   : RUN_TEST_IDLE;
      SELECT_DR_SCAN:   nxt = tms ? SELECT_IR_SCAN   : CAPTURE_DR;
      CAPTURE_DR:       nxt = tms ? EXIT1_DR         : SHIFT_DR;
      SHIFT_DR:         nxt = tms ? EXIT1_DR         : SHIFT_DR;
      EXIT1_DR:         nxt = tms ? UPDATE_DR        : PAUSE_DR;
      PAUSE_DR:         nxt = tms ? EXIT2_DR         : PAUSE_DR;
      EXIT2_DR:         nxt = tms ? UPDATE_DR        : SHIFT_DR;
      UPDATE_DR:        nxt = tms ? SELECT_DR_SCAN   : RUN_TEST_IDLE;
      SELECT_IR_SCAN:   nxt = tms ? TEST_LOGIC_RESET : CAPTURE_IR;
      CAPTURE_IR:       nxt = tms ? EXIT1_IR         : SHIFT_IR;
      SHIFT_IR:         nxt = tms ? EXIT1_IR         : SHIFT_IR;
      EXIT1_IR:         nxt = tms ? UPDATE_IR        : PAUSE_IR;
      PAUSE_IR:         nxt = tms ? EXIT2_IR         : PAUSE_IR;
      EXIT2_IR:         nxt = tms ? UPDATE_IR        : SHIFT_IR;
      UPDATE_IR:        nxt = tms ? SELECT_DR_SCAN   : RUN_TEST_IDLE;
      default:          nxt = TEST_LOGIC_RESET;
    endcase
    return nxt;
  endfunction

endpackage : jtag_pkg
`default_nettype wire

// File: rtl/jtag_tap_mirror.sv
`default_nettype none
// ============================================================================
//  Module      : jtag_tap_mirror
//  Description : Shadow copy of the TAP controller state. Advances on every
//                rising tclk using the TMS value the TAP samples at that edge;
//                forced to Test-Logic-Reset while trst is low.
//  Ports       : tclk_i  - TAP clock
//                trst_i  - asynchronous active-low TAP reset
//                tms_i   - TMS as seen by the TAP
//                state_o - mirrored TAP state
//  Revision    : 1.0  - initial release
// ============================================================================
module jtag_tap_mirror
  import jtag_pkg::*;
(
  input  logic       tclk_i,
  input  logic       trst_i,
  input  logic       tms_i,
  output tap_state_e state_o
);

  tap_state_e state_q;

  always_ff @(posedge tclk_i or negedge trst_i) begin
    if (!trst_i) begin
      state_q <= TEST_LOGIC_RESET;
    end else begin
      state_q <= tap_next_state(state_q, tms_i);
    end
  end

  assign state_o = state_q;

endmodule : jtag_tap_mirror
`default_nettype wire

// File: rtl/jtag_scan_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : jtag_scan_sequencer
//  Description : Host-side JTAG master. Accepts one scan command at a time
//                and emits the registered TMS/TDI stream that walks the TAP
//                Run-Test/Idle -> IR or DR scan -> Run-Test/Idle, capturing
//                TDO into a response word.
//  Ports       : tclk_i      - TAP clock (rising edge)
//                trst_i      - asynchronous active-low reset
//                cmd_valid_i / cmd_ready_o - command handshake
//                cmd_op_i    - 0 RESET, 1 IR_SCAN, 2 DR_SCAN, 3 IDLE
//                cmd_len_i   - scan length in bits / idle cycle count
//                cmd_data_i  - TDI bits, LSB shifted first
//                tms_o, tdi_o - registered TAP drive
//                tdo_i       - serial data from the scanned register
//                rsp_valid_o - one-cycle completion pulse
//                rsp_data_o  - captured TDO bits, held until next completion
//                tap_state_o - mirrored TAP state
//  Revision    : 1.0  - initial release
// ============================================================================
module jtag_scan_sequencer
  import jtag_pkg::*;
#(
  parameter  int MAX_LEN = 32,
  localparam int LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic               tclk_i,
  input  logic               trst_i,
  input  logic               cmd_valid_i,
  output logic               cmd_ready_o,
  input  logic [1:0]         cmd_op_i,
  input  logic [LEN_W-1:0]   cmd_len_i,
  input  logic [MAX_LEN-1:0] cmd_data_i,
  output logic               tms_o,
  output logic               tdi_o,
  input  logic               tdo_i,
  output logic               rsp_valid_o,
  output logic [MAX_LEN-1:0] rsp_data_o,
  output logic [3:0]         tap_state_o
);

  localparam int IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  seq_state_e         state_q, state_d;
  logic [LEN_W-1:0]   cnt_q,   cnt_d;
  logic [LEN_W-1:0]   len_q,   len_d;
  logic               is_ir_q, is_ir_d;
  logic [MAX_LEN-1:0] data_q,  data_d;
  logic [MAX_LEN-1:0] cap_q,   cap_d;
  logic [MAX_LEN-1:0] rsp_q,   rsp_d;
  logic               tms_q,   tms_d;
  logic               tdi_q,   tdi_d;

  logic               accept;
  logic               last_cnt;
  logic [LEN_W-1:0]   scan_len;
  tap_state_e         mirror_state;

  assign cmd_ready_o = (state_q == READY) || (state_q == DONE);
  assign accept      = cmd_valid_i && cmd_ready_o;
  assign last_cnt    = (cnt_q == (len_q - LEN_W'(1)));

  // Scan lengths are clamped to 1..MAX_LEN.
  always_comb begin
    scan_len = cmd_len_i;
    if (cmd_len_i == '0) begin
      scan_len = LEN_W'(1);
    end else if (cmd_len_i > LEN_W'(MAX_LEN)) begin
      scan_len = LEN_W'(MAX_LEN);
    end
  end

  // Next-state logic. TMS/TDI are computed from the *next* phase so that the
  // registered outputs line up with the phase during the following cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    is_ir_d = is_ir_q;
    data_d  = data_q;
    cap_d   = cap_q;
    rsp_d   = rsp_q;

    case (state_q)
      // Two cycles: the first edge after reset release drops TMS, the second
      // lets the TAP fall from Test-Logic-Reset into Run-Test/Idle.
      INIT: begin
        if (cnt_q != '0) begin
          state_d = READY;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + LEN_W'(1);
        end
      end

      READY, DONE: begin
        state_d = READY;
        if (accept) begin
          data_d  = cmd_data_i;
          cap_d   = '0;
          cnt_d   = '0;
          is_ir_d = (cmd_op_i == OP_IR_SCAN);
          case (cmd_op_i)
            OP_RESET: begin
              state_d = RST_SEQ;
              len_d   = '0;
            end
            OP_IR_SCAN, OP_DR_SCAN: begin
              state_d = SEL_DR;
              len_d   = scan_len;
            end
            default: begin // OP_IDLE
              len_d   = cmd_len_i;
              state_d = (cmd_len_i == '0) ? DONE : IDLE_CNT;
            end
          endcase
        end
      end

      SEL_DR: state_d = is_ir_q ? SEL_IR : CAPTURE;

      SEL_IR: state_d = CAPTURE;

      // Two TMS=0 cycles: Select -> Capture, then Capture -> Shift.
      CAPTURE: begin
        if (cnt_q != '0) begin
          state_d = SHIFT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + LEN_W'(1);
        end
      end

      SHIFT: begin
        cap_d[cnt_q[IDX_W-1:0]] = tdo_i;
        if (last_cnt) begin
          state_d = EXIT1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + LEN_W'(1);
        end
      end

      EXIT1: state_d = UPDATE;

      UPDATE: state_d = DONE;

      RST_SEQ: begin
        if (cnt_q == LEN_W'(RST_ONES)) begin
          state_d = DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + LEN_W'(1);
        end
      end

      IDLE_CNT: begin
        if (last_cnt) begin
          state_d = DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + LEN_W'(1);
        end
      end

      default: begin
        state_d = INIT;
        cnt_d   = '0;
      end
    endcase

    // The response word is published on entry to DONE; cap_d is already
    // cleared for commands that never shift.
    if (state_d == DONE) begin
      rsp_d = cap_d;
    end
  end

  // Output drive for the phase entered at the coming edge.
  always_comb begin
    tms_d = 1'b0;
    tdi_d = 1'b0;
    case (state_d)
      SEL_DR, SEL_IR, EXIT1: tms_d = 1'b1;
      SHIFT: begin
        tms_d = (cnt_d == (len_d - LEN_W'(1)));
        tdi_d = data_d[cnt_d[IDX_W-1:0]];
      end
      RST_SEQ: tms_d = (cnt_d < LEN_W'(RST_ONES));
      default: tms_d = 1'b0;
    endcase
  end

  always_ff @(posedge tclk_i or negedge trst_i) begin
    if (!trst_i) begin
      state_q <= INIT;
      cnt_q   <= '0;
      len_q   <= '0;
      is_ir_q <= 1'b0;
      data_q  <= '0;
      cap_q   <= '0;
      rsp_q   <= '0;
      tms_q   <= 1'b1;
      tdi_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      is_ir_q <= is_ir_d;
      data_q  <= data_d;
      cap_q   <= cap_d;
      rsp_q   <= rsp_d;
      tms_q   <= tms_d;
      tdi_q   <= tdi_d;
    end
  end

  jtag_tap_mirror u_mirror (
    .tclk_i  (tclk_i),
    .trst_i  (trst_i),
    .tms_i   (tms_q),
    .state_o (mirror_state)
  );

  assign tms_o       = tms_q;
  assign tdi_o       = tdi_q;
  assign rsp_valid_o = (state_q == DONE);
  assign rsp_data_o  = rsp_q;
  assign tap_state_o = mirror_state;

endmodule : jtag_scan_sequencer
`default_nettype wire

// File: tb/tb_jtag_scan_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_jtag_scan_sequencer
//  Description : Self-checking bench for jtag_scan_sequencer. A driver issues
//                directed and random commands and pushes the expected TMS/TDI
//                streams and response into queues; a monitor on the falling
//                edge pops and compares, and tracks its own TAP state table.
//  Revision    : 1.0  - initial release
// ============================================================================
module tb_jtag_scan_sequencer;

  localparam int MAX_LEN = 32;
  localparam int LEN_W   = 6;

  logic               tclk      = 1'b0;
  logic               trst      = 1'b1;
  logic               cmd_valid = 1'b0;
  logic [1:0]         cmd_op    = '0;
  logic [LEN_W-1:0]   cmd_len   = '0;
  logic [MAX_LEN-1:0] cmd_data  = '0;
  logic               cmd_ready;
  logic               tms;
  logic               tdi;
  logic               tdo;
  logic               rsp_valid;
  logic [MAX_LEN-1:0] rsp_data;
  logic [3:0]         tap_state;

  // TDO source: 0 loop from TDI, 1 tied high, 2 tied low, 3 inverted TDI.
  int tdo_mode = 0;
  assign tdo = (tdo_mode == 0) ? tdi  :
               (tdo_mode == 1) ? 1'b1 :
               (tdo_mode == 2) ? 1'b0 : ~tdi;

  jtag_scan_sequencer #(.MAX_LEN(MAX_LEN)) dut (
    .tclk_i      (tclk),
    .trst_i      (trst),
    .cmd_valid_i (cmd_valid),
    .cmd_ready_o (cmd_ready),
    .cmd_op_i    (cmd_op),
    .cmd_len_i   (cmd_len),
    .cmd_data_i  (cmd_data),
    .tms_o       (tms),
    .tdi_o       (tdi),
    .tdo_i       (tdo),
    .rsp_valid_o (rsp_valid),
    .rsp_data_o  (rsp_data),
    .tap_state_o (tap_state)
  );

  always #5 tclk = ~tclk;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // TAP transition table indexed by IEEE state code.
  logic [3:0] nxt0 [16] = '{4'h2, 4'h3, 4'h2, 4'h3, 4'hE, 4'hC, 4'h2, 4'h6,
                            4'hA, 4'hB, 4'hA, 4'hB, 4'hC, 4'hC, 4'hA, 4'hC};
  logic [3:0] nxt1 [16] = '{4'h5, 4'h5, 4'h1, 4'h0, 4'hF, 4'h7, 4'h1, 4'h4,
                            4'hD, 4'hD, 4'h9, 4'h8, 4'h7, 4'h7, 4'h9, 4'hF};

  logic [3:0] tap_m     = 4'hF;
  int         since_rst = 0;

  always @(posedge tclk) cyc <= cyc + 1;

  always @(posedge tclk or negedge trst) begin
    if (!trst) tap_m <= 4'hF;
    else       tap_m <= tms ? nxt1[tap_m] : nxt0[tap_m];
  end

  always @(posedge tclk or negedge trst) begin
    if (!trst)              since_rst <= 0;
    else if (since_rst < 3) since_rst <= since_rst + 1;
  end

  // Scoreboard queues.
  int                 exp_acc [$];
  int                 exp_lat [$];
  logic [MAX_LEN-1:0] exp_rsp [$];
  bit                 exp_tms [$];
  bit                 exp_tdi [$];
  logic [MAX_LEN-1:0] last_rsp = '0;

  function automatic void push_bit(input bit t, input bit d);
    exp_tms.push_back(t);
    exp_tdi.push_back(d);
  endfunction

  // ---------------------------------------------------------------- monitor
  always @(negedge tclk) begin
    if (!trst) begin
      exp_acc.delete(); exp_lat.delete(); exp_rsp.delete();
      exp_tms.delete(); exp_tdi.delete();
      last_rsp = '0;
      check("rst_tms",       tms,       1);
      check("rst_tdi",       tdi,       0);
      check("rst_ready",     cmd_ready, 0);
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_rsp_data",  rsp_data,  0);
      check("rst_tap",       tap_state, 4'hF);
    end else if (since_rst < 2) begin
      check("init_tms",       tms,       (since_rst == 0) ? 1 : 0);
      check("init_ready",     cmd_ready, 0);
      check("init_rsp_valid", rsp_valid, 0);
      check("init_tap",       tap_state, 4'hF);
    end else begin
      check("mirror", tap_state, tap_m);
      if (exp_acc.size() > 0 && (cyc - exp_acc[0]) < exp_lat[0]) begin
        if (exp_tms.size() > 0) begin
          check("tms_seq", tms, exp_tms.pop_front());
          check("tdi_seq", tdi, exp_tdi.pop_front());
        end else begin
          check("tms_queue_empty", 1, 0);
        end
        check("busy_ready",     cmd_ready, 0);
        check("busy_rsp_valid", rsp_valid, 0);
        check("busy_rsp_hold",  rsp_data,  last_rsp);
      end else begin
        check("idle_tms", tms, 0);
        check("idle_tdi", tdi, 0);
        check("ready",    cmd_ready, 1);
        if (exp_acc.size() > 0) begin
          check("rsp_valid", rsp_valid, 1);
          check("rsp_data",  rsp_data,  exp_rsp[0]);
          last_rsp = exp_rsp[0];
          void'(exp_acc.pop_front());
          void'(exp_lat.pop_front());
          void'(exp_rsp.pop_front());
        end else begin
          check("spurious_rsp_valid", rsp_valid, 0);
          check("rsp_hold",           rsp_data,  last_rsp);
        end
      end
    end
  end

  // ----------------------------------------------------------------- driver
  // Called and returns at posedge+2. Offers junk while the DUT is busy.
  task automatic issue(input logic [1:0] op, input logic [LEN_W-1:0] len,
                       input logic [MAX_LEN-1:0] data, input int mode);
    int                 guard;
    int                 n;
    int                 lat;
    logic [63:0]        mask;
    logic [MAX_LEN-1:0] word;
    guard = 0;
    while (!cmd_ready) begin
      if (guard > 200) begin
        n_cmp++;
        n_fail++;
        $display("FAIL ready_timeout: cmd_ready still 0 after %0d cycles", guard);
        cmd_valid = 1'b0;
        return;
      end
      guard++;
      cmd_valid = ($urandom_range(0, 2) == 0);
      cmd_op    = 2'($urandom);
      cmd_len   = LEN_W'($urandom);
      cmd_data  = $urandom;
      @(posedge tclk); #2;
    end
    tdo_mode  = mode;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_len   = len;
    cmd_data  = data;
    @(posedge tclk); #2;
    cmd_valid = 1'b0;
    cmd_op    = 2'($urandom);
    cmd_len   = LEN_W'($urandom);
    cmd_data  = $urandom;

    word = '0;
    case (op)
      2'd0: begin
        for (int i = 0; i < 5; i++) push_bit(1, 0);
        push_bit(0, 0);
        lat = 6;
      end
      2'd1, 2'd2: begin
        n = (len == 0) ? 1 : ((int'(len) > MAX_LEN) ? MAX_LEN : int'(len));
        push_bit(1, 0);
        if (op == 2'd1) push_bit(1, 0);
        push_bit(0, 0);
        push_bit(0, 0);
        for (int i = 0; i < n; i++) push_bit(i == n - 1, data[i]);
        push_bit(1, 0);
        push_bit(0, 0);
        lat  = n + ((op == 2'd1) ? 6 : 5);
        mask = (64'd1 << n) - 64'd1;
        case (mode)
          0:       word = data;
          1:       word = '1;
          2:       word = '0;
          default: word = ~data;
        endcase
        word = word & mask[MAX_LEN-1:0];
      end
      default: begin
        n = int'(len);
        for (int i = 0; i < n; i++) push_bit(0, 0);
        lat = n;
      end
    endcase
    exp_lat.push_back(lat);
    exp_rsp.push_back(word);
    exp_acc.push_back(cyc);
  endtask

  task automatic idle_cycles(input int k);
    repeat (k) begin @(posedge tclk); #2; end
  endtask

  initial begin
    #1 trst = 1'b0;
    repeat (3) @(posedge tclk);
    #2 trst = 1'b1;

    // Directed cases.
    issue(2'd2, 6'd8,  32'h0000_00A5, 0);
    issue(2'd1, 6'd4,  32'h0000_0003, 1);
    idle_cycles(2);
    issue(2'd0, 6'd7,  32'hFFFF_FFFF, 0);
    issue(2'd2, 6'd0,  32'hFFFF_FFFF, 0);
    issue(2'd2, 6'd40, 32'hDEAD_BEEF, 0);
    issue(2'd3, 6'd0,  32'h1234_5678, 0);
    issue(2'd3, 6'd5,  32'h1234_5678, 1);
    issue(2'd1, 6'd32, 32'hCAFE_F00D, 3);

    // Reset asserted in the middle of a shift.
    issue(2'd2, 6'd20, $urandom, 0);
    idle_cycles(8);
    trst = 1'b0;
    idle_cycles(2);
    trst = 1'b1;
    issue(2'd2, 6'd12, 32'h0000_0ABC, 0);

    // Randomised traffic.
    for (int k = 0; k < 40; k++) begin
      logic [1:0] op;
      op = 2'($urandom);
      if (op == 2'd3)
        issue(op, LEN_W'($urandom_range(0, 10)), $urandom, int'($urandom_range(0, 3)));
      else
        issue(op, LEN_W'($urandom_range(0, 63)), $urandom, int'($urandom_range(0, 3)));
      idle_cycles(int'($urandom_range(0, 2)));
    end

    // Drain the last response.
    begin
      int guard;
      guard = 0;
      while (exp_acc.size() > 0 && guard < 200) begin
        @(posedge tclk); #2;
        guard++;
      end
      if (exp_acc.size() > 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL drain_timeout: %0d responses outstanding", exp_acc.size());
      end
    end
    idle_cycles(3);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule : tb_jtag_scan_sequencer
`default_nettype wire
